// File: rtl/aurora_sup_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : aurora_sup_pkg                                         |
// | Description : Shared types, widths and helpers for the Aurora link   |
// |               supervisor and its per-channel lane.                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package aurora_sup_pkg;

  // Per-channel supervisor state; the encoding is visible on link_state.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PMA_RST  = 3'd1,
    ST_PB_RST   = 3'd2,
    ST_WAIT_UP  = 3'd3,
    ST_DEBOUNCE = 3'd4,
    ST_LINKED   = 3'd5
  } lane_state_t;

  localparam int RETRAIN_W = 8;
  localparam int SERR_W    = 16;

  // Bits needed to hold 0..value (at least one bit).
  function automatic int cnt_width(input int value);
    return (value < 1) ? 1 : $clog2(value + 1);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aurora_sup_lane.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : aurora_sup_lane                                        |
// | Description : One Aurora channel: input synchronisers, bring-up and  |
// |               retrain FSM, soft-error rate window, statistics.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module aurora_sup_lane
  import aurora_sup_pkg::*;
#(
  parameter int RST_CYCLES      = 256,
  parameter int PB_CYCLES       = 64,
  parameter int UP_TIMEOUT      = 1048576,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int WIN_CYCLES      = 65536,
  parameter int SOFT_ERR_THR    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 chn_en,
  input  logic                 channel_up,
  input  logic                 hard_err,
  input  logic                 soft_err,
  input  logic                 retrain_req,
  input  logic                 clr_cnt,
  output logic                 pma_init,
  output logic                 reset_pb,
  output logic                 link_ok,
  output logic                 tx_gate,
  output logic [2:0]           link_state,
  output logic [RETRAIN_W-1:0] retrain_cnt,
  output logic [SERR_W-1:0]    soft_err_cnt
);

  // One state timer serves every timed state, so it is sized for the longest.
  localparam int c_t_max  = max2(max2(RST_CYCLES, PB_CYCLES), max2(UP_TIMEOUT, DEBOUNCE_CYCLES));
  localparam int c_t_w    = cnt_width(c_t_max);
  localparam int c_win_w  = cnt_width(WIN_CYCLES);
  localparam int c_werr_w = cnt_width(SOFT_ERR_THR);

  localparam logic [c_t_w-1:0]   c_rst_last = c_t_w'(RST_CYCLES - 1);
  localparam logic [c_t_w-1:0]   c_pb_last  = c_t_w'(PB_CYCLES - 1);
  localparam logic [c_t_w-1:0]   c_up_last  = c_t_w'(UP_TIMEOUT - 1);
  localparam logic [c_t_w-1:0]   c_deb_last = c_t_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_win_w-1:0] c_win_last = c_win_w'(WIN_CYCLES - 1);
  localparam logic [c_werr_w:0]  c_thr      = (c_werr_w + 1)'(SOFT_ERR_THR);

  // Synchroniser bit order: {hard_err, soft_err, channel_up}
  logic [2:0]            r_sync1;
  logic [2:0]            r_sync2;
  logic                  r_soft_d;
  logic                  w_up_s;
  logic                  w_hard_s;
  logic                  w_serr_edge;

  lane_state_t           r_state;
  lane_state_t           w_state_nxt;
  logic                  w_retrain;
  logic [c_t_w-1:0]      r_timer;

  logic [c_win_w-1:0]    r_win_timer;
  logic [c_werr_w-1:0]   r_win_err;
  logic [c_werr_w:0]     w_win_err_sum;
  logic                  w_win_wrap;
  logic                  w_serr_trip;

  logic                  r_pma_init;
  logic                  r_reset_pb;
  logic                  r_link_ok;
  logic                  r_tx_gate;
  logic [RETRAIN_W-1:0]  r_retrain_cnt;
  logic [SERR_W-1:0]     r_soft_err_cnt;

  assign w_up_s      = r_sync2[0];
  assign w_hard_s    = r_sync2[2];
  assign w_serr_edge = r_sync2[1] & ~r_soft_d;

  // Two-flop synchronisers plus a delayed copy of soft_err for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_soft_d <= 1'b0;
    end else begin
      r_sync1  <= {hard_err, soft_err, channel_up};
      r_sync2  <= r_sync1;
      r_soft_d <= r_sync2[1];
    end
  end

  // Window error count including this cycle's edge; a wrap starts a fresh window.
  always_comb begin
    w_win_wrap    = (r_win_timer == c_win_last);
    w_win_err_sum = (w_win_wrap ? '0 : {1'b0, r_win_err}) + {{c_werr_w{1'b0}}, w_serr_edge};
    w_serr_trip   = (w_win_err_sum >= c_thr);
  end

  // Next-state selection; w_retrain marks transitions that count as a retrain.
  always_comb begin
    w_state_nxt = r_state;
    w_retrain   = 1'b0;
    if (!chn_en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_PMA_RST;
        ST_PMA_RST: begin
          if (r_timer == c_rst_last) w_state_nxt = ST_PB_RST;
        end
        ST_PB_RST: begin
          if (r_timer == c_pb_last) w_state_nxt = ST_WAIT_UP;
        end
        ST_WAIT_UP: begin
          if (retrain_req || (!w_up_s && r_timer == c_up_last)) begin
            w_state_nxt = ST_PMA_RST;
            w_retrain   = 1'b1;
          end else if (w_up_s) begin
            w_state_nxt = ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (retrain_req) begin
            w_state_nxt = ST_PMA_RST;
            w_retrain   = 1'b1;
          end else if (!w_up_s) begin
            w_state_nxt = ST_WAIT_UP;
          end else if (r_timer == c_deb_last) begin
            w_state_nxt = ST_LINKED;
          end
        end
        ST_LINKED: begin
          if (!w_up_s || w_hard_s || retrain_req || w_serr_trip) begin
            w_state_nxt = ST_PMA_RST;
            w_retrain   = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register, dwell timer and registered state-dependent outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_timer    <= '0;
      r_pma_init <= 1'b1;
      r_reset_pb <= 1'b1;
      r_link_ok  <= 1'b0;
      r_tx_gate  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) begin
        r_timer <= '0;
      end else if (r_state inside {ST_PMA_RST, ST_PB_RST, ST_WAIT_UP, ST_DEBOUNCE}) begin
        r_timer <= r_timer + 1'b1;
      end
      r_pma_init <= (w_state_nxt inside {ST_IDLE, ST_PMA_RST});
      r_reset_pb <= (w_state_nxt inside {ST_IDLE, ST_PMA_RST, ST_PB_RST});
      r_link_ok  <= (w_state_nxt == ST_LINKED);
      r_tx_gate  <= (w_state_nxt == ST_LINKED);
    end
  end

  // Soft-error window runs only while staying in LINKED; cleared otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_timer <= '0;
      r_win_err   <= '0;
    end else if (r_state == ST_LINKED && w_state_nxt == ST_LINKED) begin
      r_win_timer <= w_win_wrap ? '0 : r_win_timer + 1'b1;
      r_win_err   <= w_win_err_sum[c_werr_w-1:0];
    end else begin
      r_win_timer <= '0;
      r_win_err   <= '0;
    end
  end

  // Saturating statistics; a clear beats a simultaneous increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retrain_cnt  <= '0;
      r_soft_err_cnt <= '0;
    end else if (clr_cnt) begin
      r_retrain_cnt  <= '0;
      r_soft_err_cnt <= '0;
    end else begin
      if (w_retrain && r_retrain_cnt != '1)
        r_retrain_cnt <= r_retrain_cnt + 1'b1;
      if (w_serr_edge && r_soft_err_cnt != '1)
        r_soft_err_cnt <= r_soft_err_cnt + 1'b1;
    end
  end

  assign pma_init     = r_pma_init;
  assign reset_pb     = r_reset_pb;
  assign link_ok      = r_link_ok;
  assign tx_gate      = r_tx_gate;
  assign link_state   = r_state;
  assign retrain_cnt  = r_retrain_cnt;
  assign soft_err_cnt = r_soft_err_cnt;

endmodule
`default_nettype wire

// File: rtl/aurora_link_supervisor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : aurora_link_supervisor                                 |
// | Description : Supervises CH_NUM Aurora 64B66B channels: bring-up     |
// |               sequencing, link debounce, TX gating, auto-retrain     |
// |               and per-channel statistics.                            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module aurora_link_supervisor
  import aurora_sup_pkg::*;
#(
  parameter int CH_NUM          = 4,
  parameter int RST_CYCLES      = 256,
  parameter int PB_CYCLES       = 64,
  parameter int UP_TIMEOUT      = 1048576,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int WIN_CYCLES      = 65536,
  parameter int SOFT_ERR_THR    = 16
) (
  input  logic                        init_clk,
  input  logic                        system_rst_n,
  input  logic [CH_NUM-1:0]           chn_en,
  input  logic [CH_NUM-1:0]           channel_up,
  input  logic [CH_NUM-1:0]           hard_err,
  input  logic [CH_NUM-1:0]           soft_err,
  input  logic [CH_NUM-1:0]           retrain_req,
  input  logic                        clr_cnt,
  output logic [CH_NUM-1:0]           pma_init,
  output logic [CH_NUM-1:0]           reset_pb,
  output logic [CH_NUM-1:0]           link_ok,
  output logic [CH_NUM-1:0]           tx_gate,
  output logic [3*CH_NUM-1:0]         link_state,
  output logic [RETRAIN_W*CH_NUM-1:0] retrain_cnt,
  output logic [SERR_W*CH_NUM-1:0]    soft_err_cnt
);

  // Channels are independent; each lane drives its slice of the packed outputs.
  for (genvar i = 0; i < CH_NUM; i++) begin : g_lane
    aurora_sup_lane #(
      .RST_CYCLES      (RST_CYCLES),
      .PB_CYCLES       (PB_CYCLES),
      .UP_TIMEOUT      (UP_TIMEOUT),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .WIN_CYCLES      (WIN_CYCLES),
      .SOFT_ERR_THR    (SOFT_ERR_THR)
    ) u_lane (
      .clk          (init_clk),
      .rst_n        (system_rst_n),
      .chn_en       (chn_en[i]),
      .channel_up   (channel_up[i]),
      .hard_err     (hard_err[i]),
      .soft_err     (soft_err[i]),
      .retrain_req  (retrain_req[i]),
      .clr_cnt      (clr_cnt),
      .pma_init     (pma_init[i]),
      .reset_pb     (reset_pb[i]),
      .link_ok      (link_ok[i]),
      .tx_gate      (tx_gate[i]),
      .link_state   (link_state[3*i +: 3]),
      .retrain_cnt  (retrain_cnt[RETRAIN_W*i +: RETRAIN_W]),
      .soft_err_cnt (soft_err_cnt[SERR_W*i +: SERR_W])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_aurora_link_supervisor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_aurora_link_supervisor                              |
// | Description : Directed, self-checking bench for the link supervisor  |
// |               (2 channels, shortened timers).                        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_aurora_link_supervisor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  chn_en, channel_up, hard_err, soft_err, retrain_req;
  logic        clr_cnt;
  logic [1:0]  pma_init, reset_pb, link_ok, tx_gate;
  logic [5:0]  link_state;
  logic [15:0] retrain_cnt;
  logic [31:0] soft_err_cnt;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0] en;
    logic [1:0] up;
    int         n;
    logic [2:0] st1;
    logic [2:0] st0;
    logic [1:0] pma;
    logic [1:0] pb;
    logic [1:0] lnk;
    logic [1:0] txg;
    logic [7:0] rt0;
  } vec_t;

  vec_t tbl [15];
  int   pulses [11] = '{5, 25, 55, 75, 105, 125, 157, 167, 197, 207, 217};

  always #5 clk = ~clk;

  aurora_link_supervisor #(
    .CH_NUM          (2),
    .RST_CYCLES      (8),
    .PB_CYCLES       (4),
    .UP_TIMEOUT      (100),
    .DEBOUNCE_CYCLES (16),
    .WIN_CYCLES      (50),
    .SOFT_ERR_THR    (3)
  ) dut (
    .init_clk     (clk),
    .system_rst_n (rst_n),
    .chn_en       (chn_en),
    .channel_up   (channel_up),
    .hard_err     (hard_err),
    .soft_err     (soft_err),
    .retrain_req  (retrain_req),
    .clr_cnt      (clr_cnt),
    .pma_init     (pma_init),
    .reset_pb     (reset_pb),
    .link_ok      (link_ok),
    .tx_gate      (tx_gate),
    .link_state   (link_state),
    .retrain_cnt  (retrain_cnt),
    .soft_err_cnt (soft_err_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_state0(input logic [2:0] st, input int budget, input string name);
    int k;
    k = 0;
    while (link_state[2:0] !== st && k < budget) begin
      tick();
      k++;
    end
    check(name, 64'(link_state[2:0]), 64'(st));
  endtask

  initial begin
    logic p;

    // Bring-up with a debounce glitch, then link loss (channel 1 stays idle)
    tbl[0]  = '{2'b01, 2'b00,  1, 3'd0, 3'd1, 2'b11, 2'b11, 2'b00, 2'b00, 8'd0};
    tbl[1]  = '{2'b01, 2'b00,  7, 3'd0, 3'd1, 2'b11, 2'b11, 2'b00, 2'b00, 8'd0};
    tbl[2]  = '{2'b01, 2'b00,  1, 3'd0, 3'd2, 2'b10, 2'b11, 2'b00, 2'b00, 8'd0};
    tbl[3]  = '{2'b01, 2'b00,  3, 3'd0, 3'd2, 2'b10, 2'b11, 2'b00, 2'b00, 8'd0};
    tbl[4]  = '{2'b01, 2'b00,  1, 3'd0, 3'd3, 2'b10, 2'b10, 2'b00, 2'b00, 8'd0};
    tbl[5]  = '{2'b01, 2'b01,  3, 3'd0, 3'd4, 2'b10, 2'b10, 2'b00, 2'b00, 8'd0};
    tbl[6]  = '{2'b01, 2'b01,  9, 3'd0, 3'd4, 2'b10, 2'b10, 2'b00, 2'b00, 8'd0};
    tbl[7]  = '{2'b01, 2'b00,  1, 3'd0, 3'd4, 2'b10, 2'b10, 2'b00, 2'b00, 8'd0};
    tbl[8]  = '{2'b01, 2'b01,  1, 3'd0, 3'd4, 2'b10, 2'b10, 2'b00, 2'b00, 8'd0};
    tbl[9]  = '{2'b01, 2'b01,  1, 3'd0, 3'd3, 2'b10, 2'b10, 2'b00, 2'b00, 8'd0};
    tbl[10] = '{2'b01, 2'b01,  1, 3'd0, 3'd4, 2'b10, 2'b10, 2'b00, 2'b00, 8'd0};
    tbl[11] = '{2'b01, 2'b01, 15, 3'd0, 3'd4, 2'b10, 2'b10, 2'b00, 2'b00, 8'd0};
    tbl[12] = '{2'b01, 2'b01,  1, 3'd0, 3'd5, 2'b10, 2'b10, 2'b01, 2'b01, 8'd0};
    tbl[13] = '{2'b01, 2'b00,  2, 3'd0, 3'd5, 2'b10, 2'b10, 2'b01, 2'b01, 8'd0};
    tbl[14] = '{2'b01, 2'b00,  1, 3'd0, 3'd1, 2'b11, 2'b11, 2'b00, 2'b00, 8'd1};

    rst_n = 1'b0; chn_en = '0; channel_up = '0; hard_err = '0;
    soft_err = '0; retrain_req = '0; clr_cnt = 1'b0;
    repeat (3) tick();
    check("reset_outputs", 64'({link_state, pma_init, reset_pb, link_ok, tx_gate}),
          64'({6'd0, 2'b11, 2'b11, 2'b00, 2'b00}));
    check("reset_counters", 64'({retrain_cnt, soft_err_cnt}), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    for (int i = 0; i < 15; i++) begin
      chn_en = tbl[i].en;
      channel_up = tbl[i].up;
      repeat (tbl[i].n) tick();
      check($sformatf("vec%0d", i),
            64'({link_state, pma_init, reset_pb, link_ok, tx_gate, retrain_cnt[7:0]}),
            64'({tbl[i].st1, tbl[i].st0, tbl[i].pma, tbl[i].pb, tbl[i].lnk, tbl[i].txg, tbl[i].rt0}));
    end

    // Soft-error rate: 2 per window holds, wrap-cycle error opens new window, 3 trips
    channel_up = 2'b01;
    wait_state0(3'd5, 100, "relink_serr");
    for (int k = 0; k < 220; k++) begin
      p = 1'b0;
      foreach (pulses[j]) if (k == pulses[j] || k == pulses[j] + 1) p = 1'b1;
      soft_err[0] = p;
      tick();
      if (k + 1 == 150 || k + 1 == 200 || k + 1 == 219)
        check($sformatf("serr_hold_%0d", k + 1), 64'({link_state[2:0], tx_gate[0]}), 64'({3'd5, 1'b1}));
    end
    soft_err[0] = 1'b0;
    check("serr_trip", 64'({link_state[2:0], tx_gate[0], link_ok[0]}), 64'({3'd1, 1'b0, 1'b0}));
    check("serr_total", 64'(soft_err_cnt[15:0]), 64'd11);
    check("serr_retrain", 64'(retrain_cnt[7:0]), 64'd2);

    // hard_err and retrain_req reaching the FSM together count once
    wait_state0(3'd5, 100, "relink_hard");
    hard_err[0] = 1'b1;
    tick(); tick();
    check("hard_not_yet", 64'(link_state[2:0]), 64'd5);
    retrain_req[0] = 1'b1;
    tick();
    retrain_req[0] = 1'b0;
    hard_err[0] = 1'b0;
    check("dual_cause", 64'({link_state[2:0], retrain_cnt[7:0]}), 64'({3'd1, 8'd3}));
    tick();
    check("dual_once", 64'(retrain_cnt[7:0]), 64'd3);
    wait_state0(3'd2, 20, "reach_pb");
    retrain_req[0] = 1'b1;
    tick();
    retrain_req[0] = 1'b0;
    check("req_in_pb", 64'({link_state[2:0], retrain_cnt[7:0]}), 64'({3'd2, 8'd3}));

    // clr_cnt on the same cycle as a soft-error edge wins
    soft_err[0] = 1'b1;
    tick(); tick();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("clr_vs_edge", 64'({retrain_cnt, soft_err_cnt}), 64'd0);
    soft_err[0] = 1'b0;
    repeat (3) tick();
    soft_err[0] = 1'b1;
    repeat (4) tick();
    soft_err[0] = 1'b0;
    check("count_after_clr", 64'(soft_err_cnt[15:0]), 64'd1);

    // Disable while LINKED -> IDLE next cycle, statistics kept
    wait_state0(3'd5, 100, "relink_dis");
    check("relink_no_retrain", 64'(retrain_cnt[7:0]), 64'd0);
    chn_en = 2'b00;
    tick();
    check("disable_idle", 64'({link_state[2:0], pma_init[0], reset_pb[0], link_ok[0], tx_gate[0]}),
          64'({3'd0, 1'b1, 1'b1, 1'b0, 1'b0}));
    check("disable_counts", 64'({retrain_cnt[7:0], soft_err_cnt[15:0]}), 64'({8'd0, 16'd1}));

    // Asynchronous reset in the middle of PB_RST
    chn_en = 2'b01;
    wait_state0(3'd2, 30, "reach_pb2");
    tick();
    check("pb_pma_low", 64'(pma_init[0]), 64'd0);
    rst_n = 1'b0;
    #1;
    check("async_rst_out", 64'({link_state, pma_init, reset_pb, link_ok, tx_gate}),
          64'({6'd0, 2'b11, 2'b11, 2'b00, 2'b00}));
    check("async_rst_cnt", 64'({retrain_cnt, soft_err_cnt}), 64'd0);
    chn_en = 2'b00;
    channel_up = 2'b00;
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Channel 1 times out repeatedly: period 8+4+100, counter saturates at 255
    chn_en = 2'b10;
    for (int c = 1; c <= 33700; c++) begin
      tick();
      if (c == 112)
        check("to_before", 64'({link_state[5:3], retrain_cnt[15:8]}), 64'({3'd3, 8'd0}));
      if (c == 113)
        check("to_first", 64'({link_state[5:3], retrain_cnt[15:8]}), 64'({3'd1, 8'd1}));
      if (c == 11201)
        check("to_100", 64'(retrain_cnt[15:8]), 64'd100);
    end
    check("to_saturate", 64'(retrain_cnt[15:8]), 64'd255);
    check("ch0_idle", 64'(link_state[2:0]), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
